// File: rtl/nios2_debug_vjtag_pkg.sv
// ---------------------------------------------------------------------------
// nios2_debug_vjtag_pkg
// Shared types and constants for the Nios II debug virtual-JTAG host:
// host FSM state encoding, debug-slave IR codes, default scan widths and the
// DR-length clamp helper.
// ---------------------------------------------------------------------------
package nios2_debug_vjtag_pkg;

    localparam int unsigned IR_WIDTH = 2;
    localparam int unsigned DR_WIDTH = 38;
    localparam int unsigned LEN_W    = 6;

    // Host scan sequence states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } vjtag_state_e;

    // Debug-slave virtual IR codes
    localparam logic [IR_WIDTH-1:0] IR_MONDREG = 2'b00;
    localparam logic [IR_WIDTH-1:0] IR_BREAK   = 2'b01;
    localparam logic [IR_WIDTH-1:0] IR_TRACE   = 2'b10;
    localparam logic [IR_WIDTH-1:0] IR_OCIMEM  = 2'b11;

    // Requested scan length limited to the physical DR length
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/nios2_debug_vjtag_tckgen.sv
// ---------------------------------------------------------------------------
// nios2_debug_vjtag_tckgen
// TCK divider: while i_run is high, produces a TCK of 2*TCK_DIV clk per period,
// low half first. The _c pulses are high in the last clk of each half so the
// host can act on the same edge at which TCK changes.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   i_run          enable; low holds TCK at 0 and restarts the phase
//   o_tck          registered TCK
//   o_rise_en_c    next edge raises TCK (sample tdo / ir_out)
//   o_fall_en_c    next edge lowers TCK (start of next period)
// ---------------------------------------------------------------------------
module nios2_debug_vjtag_tckgen #(
    parameter int unsigned TCK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_tck,
    output logic o_rise_en_c,
    output logic o_fall_en_c
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(TCK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tck;
    logic             w_half_end;

    assign w_half_end  = i_run && (r_cnt == HALF_LAST);
    assign o_rise_en_c = w_half_end && !r_tck;
    assign o_fall_en_c = w_half_end &&  r_tck;
    assign o_tck       = r_tck;

    // Half-period counter and TCK toggle
    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_cnt <= '0;
            r_tck <= 1'b0;
        end else if (w_half_end) begin
            r_cnt <= '0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios2_debug_vjtag_host.sv
// ---------------------------------------------------------------------------
// nios2_debug_vjtag_host
// Initiator for the Nios II debug-slave virtual-JTAG link. Accepts one scan
// command, drives UIR -> CDR -> SDR xlen -> UDR [-> RTI] with one TCK period
// per strobe, captures TDO into rsp_dr and vji_ir_out into rsp_ir, then holds
// the response until rsp_ready.
// Build option: NIOS2_DEBUG_VJTAG_HOST_RTI_EN adds an RTI state of 2 TCK
// periods after UDR; otherwise vji_rti is tied 0.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   cmd_valid/ready, cmd_ir,
//   cmd_dr, cmd_len             command port (cmd_ready only in IDLE)
//   rsp_valid/ready, rsp_dr,
//   rsp_ir                      response port
//   vji_tck, vji_tdi, vji_tdo   generated TCK and shift data
//   vji_ir_in, vji_ir_out       IR to / status from the slave
//   vji_uir..vji_rti            virtual state strobes
// ---------------------------------------------------------------------------
module nios2_debug_vjtag_host #(
    parameter int unsigned IR_WIDTH = nios2_debug_vjtag_pkg::IR_WIDTH,
    parameter int unsigned DR_WIDTH = nios2_debug_vjtag_pkg::DR_WIDTH,
    parameter int unsigned TCK_DIV  = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [IR_WIDTH-1:0]                    cmd_ir,
    input  logic [DR_WIDTH-1:0]                    cmd_dr,
    input  logic [nios2_debug_vjtag_pkg::LEN_W-1:0] cmd_len,
    output logic                                   rsp_valid,
    input  logic                                   rsp_ready,
    output logic [DR_WIDTH-1:0]                    rsp_dr,
    output logic [IR_WIDTH-1:0]                    rsp_ir,
    output logic                                   vji_tck,
    output logic                                   vji_tdi,
    input  logic                                   vji_tdo,
    output logic [IR_WIDTH-1:0]                    vji_ir_in,
    input  logic [IR_WIDTH-1:0]                    vji_ir_out,
    output logic                                   vji_uir,
    output logic                                   vji_cdr,
    output logic                                   vji_sdr,
    output logic                                   vji_udr,
    output logic                                   vji_rti
);

    import nios2_debug_vjtag_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DR_WIDTH);

    vjtag_state_e        r_state;
    logic                r_run;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_dr;
    logic [IR_WIDTH-1:0] r_rsp_ir;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_bit;
    logic [DR_WIDTH-1:0] r_dr_sh;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_udr;
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
    logic                r_rti;
    logic                r_rti_second;
`endif

    logic w_tck;
    logic w_rise;
    logic w_fall;

    nios2_debug_vjtag_tckgen #(
        .TCK_DIV (TCK_DIV)
    ) u_tckgen (
        .clk         (clk),
        .reset       (reset),
        .i_run       (r_run),
        .o_tck       (w_tck),
        .o_rise_en_c (w_rise),
        .o_fall_en_c (w_fall)
    );

    // Scan sequencer; strobes/tdi change only on w_fall (start of a low half)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_run       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dr    <= '0;
            r_rsp_ir    <= '0;
            r_len       <= '0;
            r_bit       <= '0;
            r_dr_sh     <= '0;
            r_tdi       <= 1'b0;
            r_ir_in     <= '0;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_udr       <= 1'b0;
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
            r_rti        <= 1'b0;
            r_rti_second <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_ir_in     <= cmd_ir;
                        r_dr_sh     <= cmd_dr;
                        r_len       <= clamp_len(cmd_len, MAX_LEN);
                        r_bit       <= '0;
                        r_rsp_dr    <= '0;
                        r_rsp_ir    <= '0;
                        r_run       <= 1'b1;
                        r_uir       <= 1'b1;
                        r_state     <= ST_UIR;
                    end
                end
                ST_UIR: begin
                    if (w_rise) begin
                        r_rsp_ir <= vji_ir_out;
                    end
                    if (w_fall) begin
                        r_uir   <= 1'b0;
                        r_cdr   <= 1'b1;
                        r_state <= ST_CDR;
                    end
                end
                ST_CDR: begin
                    if (w_fall) begin
                        r_cdr <= 1'b0;
                        if (r_len != '0) begin
                            r_sdr   <= 1'b1;
                            r_tdi   <= r_dr_sh[0];
                            r_state <= ST_SDR;
                        end else begin
                            r_udr   <= 1'b1;
                            r_state <= ST_UDR;
                        end
                    end
                end
                ST_SDR: begin
                    if (w_rise) begin
                        r_rsp_dr[r_bit] <= vji_tdo;
                    end
                    if (w_fall) begin
                        if (r_bit == r_len - LEN_W'(1)) begin
                            // Last bit done; counter stays saturated
                            r_sdr   <= 1'b0;
                            r_tdi   <= 1'b0;
                            r_udr   <= 1'b1;
                            r_state <= ST_UDR;
                        end else begin
                            r_bit   <= r_bit + LEN_W'(1);
                            r_tdi   <= r_dr_sh[1];
                            r_dr_sh <= r_dr_sh >> 1;
                        end
                    end
                end
                ST_UDR: begin
                    if (w_fall) begin
                        r_udr <= 1'b0;
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
                        r_rti        <= 1'b1;
                        r_rti_second <= 1'b0;
                        r_state      <= ST_RTI;
`else
                        r_run   <= 1'b0;
                        r_ir_in <= '0;
                        r_state <= ST_RESP;
`endif
                    end
                end
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
                ST_RTI: begin
                    // Two TCK periods in run-test-idle for the slave handshake
                    if (w_fall) begin
                        if (r_rti_second) begin
                            r_rti   <= 1'b0;
                            r_run   <= 1'b0;
                            r_ir_in <= '0;
                            r_state <= ST_RESP;
                        end else begin
                            r_rti_second <= 1'b1;
                        end
                    end
                end
`endif
                ST_RESP: begin
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dr    = r_rsp_dr;
    assign rsp_ir    = r_rsp_ir;
    assign vji_tck   = w_tck;
    assign vji_tdi   = r_tdi;
    assign vji_ir_in = r_ir_in;
    assign vji_uir   = r_uir;
    assign vji_cdr   = r_cdr;
    assign vji_sdr   = r_sdr;
    assign vji_udr   = r_udr;
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
    assign vji_rti   = r_rti;
`else
    assign vji_rti   = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_debug_vjtag_host.sv
// ---------------------------------------------------------------------------
// tb_nios2_debug_vjtag_host
// Self-checking bench: table vectors, random scans against a reference model,
// response back-pressure, reset mid-scan, and a TCK_DIV=1 instance with a
// clamped long scan. Honours NIOS2_DEBUG_VJTAG_HOST_RTI_EN.
// ---------------------------------------------------------------------------
module tb_nios2_debug_vjtag_host;
    import nios2_debug_vjtag_pkg::*;

    localparam int unsigned TD = 4;
    localparam int unsigned DW = 38;
    localparam int unsigned IW = 2;
`ifdef NIOS2_DEBUG_VJTAG_HOST_RTI_EN
    localparam int unsigned RTI_P = 2;
`else
    localparam int unsigned RTI_P = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    always #5 clk = ~clk;

    // Main instance (TCK_DIV = 4)
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [IW-1:0] cmd_ir, rsp_ir, vji_ir_in, vji_ir_out;
    logic [DW-1:0] cmd_dr, rsp_dr;
    logic [5:0]    cmd_len;
    logic          vji_tck, vji_tdi, vji_tdo;
    logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic          tdo_key;
    logic [IW-1:0] ir_status;

    // Slave stand-in: tdo = tdi xor per-scan key; ir_out valid only during UIR
    assign vji_tdo    = vji_tdi ^ tdo_key;
    assign vji_ir_out = vji_uir ? ir_status : ~ir_status;

    nios2_debug_vjtag_host #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_DIV(TD)) u_dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_dr(cmd_dr), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir(rsp_ir),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
        .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_udr(vji_udr), .vji_rti(vji_rti)
    );

    // Second instance (TCK_DIV = 1), tdo looped to tdi
    logic          cmd_valid1, cmd_ready1, rsp_valid1;
    logic          rsp_ready1 = 1'b1;
    logic [IW-1:0] rsp_ir1, vji_ir_in1;
    logic [IW-1:0] vji_ir_out1 = 2'b11;
    logic [DW-1:0] rsp_dr1;
    logic          vji_tck1, vji_tdi1;
    logic          vji_uir1, vji_cdr1, vji_sdr1, vji_udr1, vji_rti1;

    nios2_debug_vjtag_host #(.IR_WIDTH(IW), .DR_WIDTH(DW), .TCK_DIV(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ir(cmd_ir),
        .cmd_dr(cmd_dr), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_dr(rsp_dr1), .rsp_ir(rsp_ir1),
        .vji_tck(vji_tck1), .vji_tdi(vji_tdi1), .vji_tdo(vji_tdi1),
        .vji_ir_in(vji_ir_in1), .vji_ir_out(vji_ir_out1),
        .vji_uir(vji_uir1), .vji_cdr(vji_cdr1), .vji_sdr(vji_sdr1),
        .vji_udr(vji_udr1), .vji_rti(vji_rti1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: bit i of the response is tdi bit i xor key for i < clamped len
    function automatic logic [DW-1:0] model_dr(input logic [DW-1:0] dr, input int clen,
                                               input logic key);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < clen; i++) r[i] = dr[i] ^ key;
        return r;
    endfunction

    // Observation counters for the main instance, sampled mid-cycle
    int            n_uir, n_cdr, n_sdr, n_udr, n_rti, n_tck_hi, n_rise, n_sdr_rise;
    int            n_multi, n_irbad, n_idlebad;
    logic          prev_tck = 1'b0;
    logic          mon_en = 1'b0;
    logic [IW-1:0] exp_ir_in;

    always @(negedge clk) begin
        int s;
        if (mon_en) begin
            s = 32'(vji_uir) + 32'(vji_cdr) + 32'(vji_sdr) + 32'(vji_udr) + 32'(vji_rti);
            if (vji_uir) n_uir++;
            if (vji_cdr) n_cdr++;
            if (vji_sdr) n_sdr++;
            if (vji_udr) n_udr++;
            if (vji_rti) n_rti++;
            if (vji_tck) n_tck_hi++;
            if (vji_tck && !prev_tck) begin
                n_rise++;
                if (vji_sdr) n_sdr_rise++;
            end
            if (s > 1) n_multi++;
            if ((vji_uir || vji_cdr || vji_sdr || vji_udr) && vji_ir_in !== exp_ir_in) n_irbad++;
            if (cmd_ready && (vji_ir_in != '0 || s != 0 || vji_tck || rsp_valid)) n_idlebad++;
            prev_tck = vji_tck;
        end
    end

    task automatic clear_mon();
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
        n_tck_hi = 0; n_rise = 0; n_sdr_rise = 0; n_multi = 0; n_irbad = 0;
    endtask

    task automatic run_txn(input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                           input logic [5:0] len, input logic key, input int stall,
                           input logic [DW-1:0] exp_dr);
        int            clen, periods, cyc, bad;
        logic [DW-1:0] held_dr;
        logic [IW-1:0] held_ir;
        clen    = (int'(len) > int'(DW)) ? int'(DW) : int'(len);
        periods = 3 + clen + int'(RTI_P);
        @(negedge clk);
        cmd_ir    = ir;
        cmd_dr    = dr;
        cmd_len   = len;
        tdo_key   = key;
        ir_status = IW'($urandom);
        exp_ir_in = ir;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        clear_mon();
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(periods * 2 * int'(TD) + 1));
        chk("rsp_dr", 64'(rsp_dr), 64'(exp_dr));
        chk("rsp_ir", 64'(rsp_ir), 64'(ir_status));
        chk("uir_clk", 64'(n_uir), 64'(2 * TD));
        chk("cdr_clk", 64'(n_cdr), 64'(2 * TD));
        chk("sdr_clk", 64'(n_sdr), 64'(clen * 2 * int'(TD)));
        chk("udr_clk", 64'(n_udr), 64'(2 * TD));
        chk("rti_clk", 64'(n_rti), 64'(RTI_P * 2 * TD));
        chk("tck_rises", 64'(n_rise), 64'(periods));
        chk("sdr_rises", 64'(n_sdr_rise), 64'(clen));
        chk("tck_high_clk", 64'(n_tck_hi), 64'(periods * int'(TD)));
        chk("one_strobe", 64'(n_multi), 64'(0));
        chk("ir_in_held", 64'(n_irbad), 64'(0));
        chk("idle_quiet", 64'(n_idlebad), 64'(0));
        held_dr = rsp_dr;
        held_ir = rsp_ir;
        bad = 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dr !== held_dr || rsp_ir !== held_ir ||
                cmd_ready !== 1'b0) bad++;
        end
        if (stall > 0) chk("stall_stable", 64'(bad), 64'(0));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid_drop", 64'(rsp_valid), 64'(0));
        chk("hs_ready_back", 64'(cmd_ready), 64'(1));
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [IW-1:0] ir;
        logic [DW-1:0] dr;
        logic [5:0]    len;
        logic          key;
        int            stall;
        logic [DW-1:0] exp_dr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            cyc, bad, n1_sdr, n1_rise, clen;
        logic          prev1;
        logic [IW-1:0] rir;
        logic [DW-1:0] rdr;
        logic [5:0]    rlen;
        logic          rkey;

        vecs[0] = '{IR_BREAK,   38'h2A_DEADBEEF, 6'd38, 1'b0, 0,  38'h2A_DEADBEEF};
        vecs[1] = '{IR_TRACE,   38'h3F_FFFFFFFF, 6'd0,  1'b0, 0,  38'h0};
        vecs[2] = '{IR_OCIMEM,  38'h3F_FFFFFFFF, 6'd4,  1'b1, 0,  38'h0};
        vecs[3] = '{IR_MONDREG, 38'h01_23456789, 6'd8,  1'b0, 20, 38'h89};
        vecs[4] = '{IR_BREAK,   38'h2A_DEADBEEF, 6'd50, 1'b0, 0,  38'h2A_DEADBEEF};
        vecs[5] = '{IR_OCIMEM,  38'h0F_0F0F0F0F, 6'd12, 1'b1, 3,  38'h0F0};
        vecs[6] = '{IR_TRACE,   38'h20_00000001, 6'd1,  1'b0, 0,  38'h1};
        vecs[7] = '{IR_MONDREG, 38'h20_00000001, 6'd37, 1'b1, 0,  38'h1F_FFFFFFFE};

        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid1 = 1'b0;
        rsp_ready  = 1'b0;
        cmd_ir     = '0;
        cmd_dr     = '0;
        cmd_len    = '0;
        tdo_key    = 1'b0;
        ir_status  = '0;
        exp_ir_in  = '0;
        n_idlebad  = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_dr", 64'(rsp_dr), 64'(0));
        chk("rst_rsp_ir", 64'(rsp_ir), 64'(0));
        chk("rst_tck_tdi", 64'({vji_tck, vji_tdi}), 64'(0));
        chk("rst_ir_in", 64'(vji_ir_in), 64'(0));
        chk("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < 8; v++)
            run_txn(vecs[v].ir, vecs[v].dr, vecs[v].len, vecs[v].key, vecs[v].stall,
                    vecs[v].exp_dr);

        for (int r = 0; r < 20; r++) begin
            rir  = IW'($urandom);
            rdr  = DW'({$urandom(), $urandom()});
            rlen = 6'($urandom_range(0, 63));
            rkey = 1'($urandom);
            clen = (int'(rlen) > int'(DW)) ? int'(DW) : int'(rlen);
            run_txn(rir, rdr, rlen, rkey, $urandom_range(0, 3), model_dr(rdr, clen, rkey));
        end

        // Reset during SDR bit 10 aborts the scan without a response
        @(negedge clk);
        cmd_ir    = IR_BREAK;
        cmd_dr    = 38'h15_55555555;
        cmd_len   = 6'd38;
        tdo_key   = 1'b0;
        exp_ir_in = IR_BREAK;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        clear_mon();
        cyc = 0;
        while (n_sdr_rise < 10 && cyc < 2000) begin @(negedge clk); cyc++; end
        while (vji_tck !== 1'b0 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("abort_in_sdr", 64'(vji_sdr), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'(0));
        chk("abort_tck", 64'(vji_tck), 64'(0));
        chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        chk("abort_no_rsp", 64'(bad), 64'(0));
        run_txn(IR_TRACE, 38'h12_34567890, 6'd16, 1'b0, 0, 38'h7890);

        // TCK_DIV = 1 instance: clamped 50-bit request, 2-clk TCK period
        @(negedge clk);
        cmd_ir     = IR_BREAK;
        cmd_dr     = 38'h2A_DEADBEEF;
        cmd_len    = 6'd50;
        chk("d1_cmd_ready", 64'(cmd_ready1), 64'(1));
        cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        cyc = 0; n1_sdr = 0; n1_rise = 0; prev1 = 1'b0;
        while (rsp_valid1 !== 1'b1 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (vji_sdr1) n1_sdr++;
            if (vji_tck1 && !prev1) n1_rise++;
            prev1 = vji_tck1;
        end
        chk("d1_latency", 64'(cyc), 64'((3 + 38 + int'(RTI_P)) * 2 + 1));
        chk("d1_sdr_clk", 64'(n1_sdr), 64'(76));
        chk("d1_tck_rises", 64'(n1_rise), 64'(41 + RTI_P));
        chk("d1_rsp_dr", 64'(rsp_dr1), 64'(38'h2A_DEADBEEF));
        chk("d1_rsp_ir", 64'(rsp_ir1), 64'(2'b11));
        repeat (2) @(posedge clk);
        #1;
        chk("d1_back_idle", 64'({cmd_ready1, rsp_valid1}), 64'(2'b10));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
